// File: rtl/brch_pred_upd_ctrl_pkg.sv
// Shared types and default sizes for the branch prediction table update controller.
package brch_pred_pkg;

  localparam int IDX_W_DEF = 5;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // NORMAL: lookups own the table port, updates drain on idle cycles.
  // FORCE_DRAIN: FIFO is close to full, updates own the port and lookups stall.
  typedef enum logic [0:0] {
    NORMAL      = 1'b0,
    FORCE_DRAIN = 1'b1
  } upd_state_e;

  // One pending table update at the default index width.
  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 taken;
  } brch_upd_t;

endpackage

// File: rtl/brch_upd_fifo.sv
// Pending-update FIFO with a parallel lookup bypass that returns the youngest
// matching entry. The entry pushed this cycle is not yet visible to the bypass.
module brch_upd_fifo
  import brch_pred_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [IDX_W-1:0] push_idx_i,
  input  logic             push_taken_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] lkp_idx_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_taken_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o,
  output logic             hit_o,
  output logic             hit_taken_o
);

  logic [IDX_W-1:0] mem_idx_q [DEPTH];
  logic [IDX_W-1:0] mem_idx_d [DEPTH];
  logic             mem_tk_q  [DEPTH];
  logic             mem_tk_d  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage write, pointer advance (wraps modulo DEPTH) and occupancy update.
  always_comb begin
    mem_idx_d = mem_idx_q;
    mem_tk_d  = mem_tk_q;
    if (push_i) begin
      mem_idx_d[wr_ptr_q] = push_idx_i;
      mem_tk_d[wr_ptr_q]  = push_taken_i;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Scan from head (oldest) to tail; later matches overwrite earlier ones so
  // the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot        = '0;
    hit_o       = 1'b0;
    hit_taken_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((CW'(i) < count_q) && (mem_idx_q[slot] == lkp_idx_i)) begin
        hit_o       = 1'b1;
        hit_taken_o = mem_tk_q[slot];
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx_q[i] <= '0;
        mem_tk_q[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_idx_q <= mem_idx_d;
      mem_tk_q  <= mem_tk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head_idx_o   = mem_idx_q[rd_ptr_q];
  assign head_taken_o = mem_tk_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/brch_pred_upd_ctrl.sv
// Sequences a single-ported 1-bit branch prediction table between IF lookups
// and buffered ID-stage outcome updates; flags mispredicts and keeps stats.
// Table port handshake: tbl_en is a one-cycle request that the table always
// accepts; lookup_stall=1 means the IF lookup was not issued and IF must hold.
module brch_pred_upd_ctrl
  import brch_pred_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_req_IF,
  input  logic [IDX_W-1:0]       lookup_idx_IF,
  input  logic                   brch_resolved_ID,
  input  logic                   stall_ID,
  input  logic [IDX_W-1:0]       resolve_idx_ID,
  input  logic                   actual_taken_ID,
  input  logic                   predicted_taken_ID,
  output logic                   tbl_en,
  output logic                   tbl_we,
  output logic [IDX_W-1:0]       tbl_idx,
  output logic                   tbl_wdata,
  output logic                   lookup_stall,
  output logic                   byp_vld,
  output logic                   byp_taken,
  output logic                   mispredict_flush,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       brch_cnt,
  output logic [CNT_W-1:0]       mispred_cnt,
  output upd_state_e             state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  upd_state_e       state_q, state_d;
  logic [CNT_W-1:0] brch_cnt_q, brch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             res_vld;
  logic             pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             fifo_empty;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             hit;
  logic             hit_taken;

  assign res_vld          = brch_resolved_ID & ~stall_ID;
  assign mispredict_flush = res_vld & (actual_taken_ID != predicted_taken_ID);

  brch_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (res_vld),
    .push_idx_i   (resolve_idx_ID),
    .push_taken_i (actual_taken_ID),
    .pop_i        (pop),
    .lkp_idx_i    (lookup_idx_IF),
    .head_idx_o   (head_idx),
    .head_taken_o (head_taken),
    .empty_o      (fifo_empty),
    .count_o      (count_q),
    .count_next_o (count_next),
    .hit_o        (hit),
    .hit_taken_o  (hit_taken)
  );

  // Table port arbitration: lookups first in NORMAL, updates only in FORCE_DRAIN.
  always_comb begin
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_idx      = '0;
    tbl_wdata    = 1'b0;
    pop          = 1'b0;
    lookup_stall = 1'b0;
    if (state_q == FORCE_DRAIN) begin
      lookup_stall = lookup_req_IF;
      if (!fifo_empty) begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_idx   = head_idx;
        tbl_wdata = head_taken;
        pop       = 1'b1;
      end
    end else if (lookup_req_IF) begin
      tbl_en  = 1'b1;
      tbl_idx = lookup_idx_IF;
    end else if (!fifo_empty) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_idx   = head_idx;
      tbl_wdata = head_taken;
      pop       = 1'b1;
    end
  end

  // Bypass is only meaningful for a lookup that is actually issued.
  always_comb begin
    byp_vld   = lookup_req_IF & ~lookup_stall & hit;
    byp_taken = byp_vld & hit_taken;
  end

  // Next state from post-cycle occupancy, with hysteresis down to half full.
  always_comb begin
    state_d = state_q;
    if (state_q == NORMAL) begin
      if (count_next == CW'(DEPTH)) state_d = FORCE_DRAIN;
    end else begin
      if (count_next <= CW'(DEPTH / 2)) state_d = NORMAL;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    brch_cnt_d    = brch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_vld && (brch_cnt_q != CNT_MAX)) brch_cnt_d = brch_cnt_q + CNT_W'(1);
    if (mispredict_flush && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= NORMAL;
      brch_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      brch_cnt_q    <= brch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign fifo_count  = count_q;
  assign brch_cnt    = brch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_brch_pred_upd_ctrl.sv
// Directed bench for brch_pred_upd_ctrl: hand-computed per-cycle expectations
// plus an in-order scoreboard for table writes.
module tb_brch_pred_upd_ctrl;
  import brch_pred_pkg::*;

  localparam int IDX_W = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             lookup_req_IF;
  logic [IDX_W-1:0] lookup_idx_IF;
  logic             brch_resolved_ID;
  logic             stall_ID;
  logic [IDX_W-1:0] resolve_idx_ID;
  logic             actual_taken_ID;
  logic             predicted_taken_ID;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic             tbl_wdata;
  logic             lookup_stall;
  logic             byp_vld;
  logic             byp_taken;
  logic             mispredict_flush;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] brch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  upd_state_e       state_dbg;

  int n_tests;
  int n_fail;
  logic [IDX_W:0] exp_q[$];
  logic [IDX_W:0] mon_w;

  brch_pred_upd_ctrl #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lookup_req_IF      (lookup_req_IF),
    .lookup_idx_IF      (lookup_idx_IF),
    .brch_resolved_ID   (brch_resolved_ID),
    .stall_ID           (stall_ID),
    .resolve_idx_ID     (resolve_idx_ID),
    .actual_taken_ID    (actual_taken_ID),
    .predicted_taken_ID (predicted_taken_ID),
    .tbl_en             (tbl_en),
    .tbl_we             (tbl_we),
    .tbl_idx            (tbl_idx),
    .tbl_wdata          (tbl_wdata),
    .lookup_stall       (lookup_stall),
    .byp_vld            (byp_vld),
    .byp_taken          (byp_taken),
    .mispredict_flush   (mispredict_flush),
    .fifo_count         (fifo_count),
    .brch_cnt           (brch_cnt),
    .mispred_cnt        (mispred_cnt),
    .state_dbg          (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic res_clear();
    brch_resolved_ID   = 1'b0;
    stall_ID           = 1'b0;
    resolve_idx_ID     = '0;
    actual_taken_ID    = 1'b0;
    predicted_taken_ID = 1'b0;
  endtask

  task automatic lookup(input logic req, input logic [IDX_W-1:0] idx);
    lookup_req_IF = req;
    lookup_idx_IF = idx;
  endtask

  task automatic resolve(input logic [IDX_W-1:0] idx, input logic act, input logic pred,
                         input logic stall);
    brch_upd_t u;
    brch_resolved_ID   = 1'b1;
    stall_ID           = stall;
    resolve_idx_ID     = idx;
    actual_taken_ID    = act;
    predicted_taken_ID = pred;
    if (!stall) begin
      u = '{idx: idx, taken: act};
      exp_q.push_back(u);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [IDX_W-1:0] idx, input logic data);
    chk({tag, "_en"}, tbl_en, 1);
    chk({tag, "_we"}, tbl_we, 1);
    chk({tag, "_idx"}, tbl_idx, idx);
    chk({tag, "_wdata"}, tbl_wdata, data);
  endtask

  task automatic chk_rd(input string tag, input logic [IDX_W-1:0] idx);
    chk({tag, "_en"}, tbl_en, 1);
    chk({tag, "_we"}, tbl_we, 0);
    chk({tag, "_idx"}, tbl_idx, idx);
    chk({tag, "_wdata"}, tbl_wdata, 0);
  endtask

  // Scoreboard: every table write must be the oldest outstanding resolution.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tbl_en && tbl_we) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 1, 0);
        end else begin
          mon_w = exp_q.pop_front();
          chk("sb_write_order", {tbl_idx, tbl_wdata}, mon_w);
        end
      end else begin
        chk("sb_wdata_zero_on_read", tbl_wdata, 0);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    lookup(0, '0);
    res_clear();
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst_count", fifo_count, 0);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_stall", lookup_stall, 0);
    chk("rst_byp", byp_vld, 0);
    chk("rst_flush", mispredict_flush, 0);
    chk("rst_brch", brch_cnt, 0);
    chk("rst_misp", mispred_cnt, 0);
    chk("rst_state", state_dbg, NORMAL);

    // Single mispredicted resolution, written back on the next idle cycle.
    tick(); resolve(3, 1, 0, 0); settle();
    chk("t1_flush", mispredict_flush, 1);
    chk("t1_idle_en", tbl_en, 0);
    tick(); res_clear(); settle();
    chk_wr("t1_wr", 3, 1);
    chk("t1_count1", fifo_count, 1);
    chk("t1_brch", brch_cnt, 1);
    chk("t1_misp", mispred_cnt, 1);
    chk("t1_flush_off", mispredict_flush, 0);
    tick(); settle();
    chk("t1_count0", fifo_count, 0);
    chk("t1_en0", tbl_en, 0);

    // Bypass: two pending updates to idx 7, youngest wins; no writes meanwhile.
    tick(); lookup(1, 7); resolve(7, 0, 0, 0); settle();
    chk_rd("t2_rd0", 7);
    chk("t2_byp0", byp_vld, 0);
    chk("t2_noflush", mispredict_flush, 0);
    tick(); resolve(7, 1, 1, 0); settle();
    chk_rd("t2_rd1", 7);
    chk("t2_count1", fifo_count, 1);
    chk("t2_byp1", byp_vld, 1);
    chk("t2_byp1_tk", byp_taken, 0);
    tick(); res_clear(); settle();
    chk_rd("t2_rd2", 7);
    chk("t2_count2", fifo_count, 2);
    chk("t2_byp2", byp_vld, 1);
    chk("t2_byp2_tk", byp_taken, 1);
    tick(); lookup(0, '0); settle();
    chk_wr("t2_wr0", 7, 0);
    chk("t2_byp_idle", byp_vld, 0);
    tick(); settle();
    chk_wr("t2_wr1", 7, 1);
    chk("t2_count_d1", fifo_count, 1);
    tick(); settle();
    chk("t2_count0", fifo_count, 0);
    chk("t2_en0", tbl_en, 0);
    chk("t2_brch", brch_cnt, 3);
    chk("t2_misp", mispred_cnt, 1);

    // Continuous lookups at idx 2 force the FIFO full -> FORCE_DRAIN.
    tick(); lookup(1, 2); resolve(1, 1, 1, 0); settle();
    chk_rd("t3_c0", 2);
    chk("t3_c0_byp", byp_vld, 0);
    tick(); resolve(2, 0, 0, 0); settle();
    chk("t3_c1_count", fifo_count, 1);
    chk("t3_c1_byp", byp_vld, 0);
    tick(); resolve(4, 1, 1, 0); settle();
    chk("t3_c2_count", fifo_count, 2);
    chk("t3_c2_byp", byp_vld, 1);
    chk("t3_c2_byp_tk", byp_taken, 0);
    tick(); resolve(5, 0, 1, 0); settle();
    chk("t3_c3_count", fifo_count, 3);
    chk("t3_c3_state", state_dbg, NORMAL);
    chk("t3_c3_flush", mispredict_flush, 1);
    chk_rd("t3_c3", 2);
    tick(); res_clear(); settle();
    chk("t3_c4_count", fifo_count, 4);
    chk("t3_c4_state", state_dbg, FORCE_DRAIN);
    chk("t3_c4_stall", lookup_stall, 1);
    chk("t3_c4_byp", byp_vld, 0);
    chk_wr("t3_c4_wr", 1, 1);
    tick(); settle();
    chk("t3_c5_count", fifo_count, 3);
    chk("t3_c5_stall", lookup_stall, 1);
    chk_wr("t3_c5_wr", 2, 0);
    tick(); resolve(6, 1, 1, 0); settle();
    chk("t3_c6_count", fifo_count, 2);
    chk("t3_c6_state", state_dbg, NORMAL);
    chk("t3_c6_stall", lookup_stall, 0);
    chk_rd("t3_c6", 2);
    chk("t3_c6_byp", byp_vld, 0);
    tick(); resolve(8, 0, 0, 0); settle();
    chk("t3_c7_count", fifo_count, 3);
    chk_rd("t3_c7", 2);

    // Resolution while full in FORCE_DRAIN: push and pop together.
    tick(); resolve(10, 1, 1, 0); settle();
    chk("t4_c8_count", fifo_count, 4);
    chk("t4_c8_state", state_dbg, FORCE_DRAIN);
    chk_wr("t4_c8_wr", 4, 1);
    tick(); res_clear(); settle();
    chk("t4_c9_count", fifo_count, 4);
    chk_wr("t4_c9_wr", 5, 0);
    tick(); settle();
    chk("t4_c10_count", fifo_count, 3);
    chk_wr("t4_c10_wr", 6, 1);
    tick(); lookup(0, '0); settle();
    chk("t4_c11_count", fifo_count, 2);
    chk("t4_c11_state", state_dbg, NORMAL);
    chk_wr("t4_c11_wr", 8, 0);
    tick(); settle();
    chk_wr("t4_c12_wr", 10, 1);
    tick(); settle();
    chk("t4_count0", fifo_count, 0);
    chk("t4_brch", brch_cnt, 10);
    chk("t4_misp", mispred_cnt, 2);

    // Resolution during an ID stall is ignored entirely.
    tick(); resolve(12, 1, 0, 1); settle();
    chk("t5_flush", mispredict_flush, 0);
    chk("t5_en", tbl_en, 0);
    tick(); res_clear(); settle();
    chk("t5_count", fifo_count, 0);
    chk("t5_brch", brch_cnt, 10);
    chk("t5_misp", mispred_cnt, 2);

    // Reset while in FORCE_DRAIN with 3 entries pending.
    tick(); lookup(1, 13); resolve(11, 1, 1, 0);
    tick(); resolve(12, 0, 0, 0);
    tick(); resolve(13, 1, 1, 0);
    tick(); resolve(14, 0, 0, 0); settle();
    chk("t6_count3", fifo_count, 3);
    tick(); res_clear(); settle();
    chk("t6_state_fd", state_dbg, FORCE_DRAIN);
    chk_wr("t6_wr", 11, 1);
    tick(); settle();
    chk("t6_pre_count", fifo_count, 3);
    chk("t6_pre_state", state_dbg, FORCE_DRAIN);
    chk("t6_pre_brch", brch_cnt, 14);
    rst_n = 1'b0;
    lookup(0, '0);
    exp_q.delete();
    tick(); rst_n = 1'b1; settle();
    chk("t6_count", fifo_count, 0);
    chk("t6_state", state_dbg, NORMAL);
    chk("t6_en", tbl_en, 0);
    chk("t6_stall", lookup_stall, 0);
    chk("t6_brch", brch_cnt, 0);
    chk("t6_misp", mispred_cnt, 0);
    tick(); lookup(1, 13); settle();
    chk("t6_byp", byp_vld, 0);
    chk_rd("t6_rd", 13);
    tick(); lookup(0, '0);

    // Saturation: bring both counters to max-1, then resolve twice more.
    for (int k = 0; k < 14; k++) begin
      tick(); resolve(20, 1, 0, 0); settle();
      chk("t7_flush", mispredict_flush, 1);
    end
    tick(); res_clear(); settle();
    chk("t7_brch_m1", brch_cnt, 14);
    chk("t7_misp_m1", mispred_cnt, 14);
    tick(); resolve(21, 0, 1, 0);
    tick(); res_clear(); settle();
    chk("t7_brch_max", brch_cnt, 15);
    chk("t7_misp_max", mispred_cnt, 15);
    tick(); resolve(22, 1, 0, 0); settle();
    chk("t7_flush_sat", mispredict_flush, 1);
    tick(); res_clear(); settle();
    chk("t7_brch_hold", brch_cnt, 15);
    chk("t7_misp_hold", mispred_cnt, 15);

    tick(); tick(); tick(); settle();
    chk("end_count", fifo_count, 0);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brch_pred_upd_ctrl.md
Name: brch_pred_upd_ctrl

Overview:
Controller that sequences a single-ported 1-bit branch prediction table shared by IF-stage lookups and ID-stage outcome updates. Lookups normally have priority. Resolved outcomes are buffered in a small update FIFO and written back on idle table cycles. A lookup that matches a pending update gets the buffered value through a bypass. The block also flags mispredictions for pipeline flush and keeps saturating branch and mispredict statistics.

Parameters:
IDX_W, 5, table index width (low PC bits)
DEPTH, 4, update FIFO entries; power of 2, >= 2
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lookup_req_IF  in  1  branch detected in IF; table read requested
lookup_idx_IF  in  IDX_W  lookup index
brch_resolved_ID  in  1  branch outcome known in ID
stall_ID  in  1  hazard stall; resolution ignored while high
resolve_idx_ID  in  IDX_W  index of resolving branch
actual_taken_ID  in  1  resolved direction
predicted_taken_ID  in  1  direction predicted for this branch in IF
tbl_en  out  1  table access this cycle
tbl_we  out  1  1 = write, 0 = read
tbl_idx  out  IDX_W  table address
tbl_wdata  out  1  write data (taken bit)
lookup_stall  out  1  lookup refused this cycle; IF must hold
byp_vld  out  1  lookup hits a pending FIFO entry
byp_taken  out  1  bypassed prediction value
mispredict_flush  out  1  flush younger instructions, redirect
fifo_count  out  $clog2(DEPTH)+1  occupancy
brch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied; pending updates dropped. Counters = 0. State = NORMAL. Reset value of every registered output is 0. Combinational outputs reflect the empty, NORMAL state.
- Valid resolution: res_vld = brch_resolved_ID & !stall_ID. res_vld pushes {resolve_idx_ID, actual_taken_ID} at the tail on the next posedge.
- mispredict_flush = res_vld & (actual_taken_ID != predicted_taken_ID). Combinational, zero latency.
- brch_cnt += 1 on res_vld. mispred_cnt += 1 on mispredict_flush. Both saturate at all-ones; no wrap.
- FSM state is registered; next state is computed from count_next (occupancy after this cycle's push/pop).
- NORMAL state, table port priority:
  - lookup_req_IF: tbl_en=1, tbl_we=0, tbl_idx=lookup_idx_IF, no pop.
  - Else if FIFO not empty: tbl_en=1, tbl_we=1, tbl_idx/tbl_wdata from head; pop.
  - Else: tbl_en=0.
- FORCE_DRAIN state:
  - Head is written and popped every cycle.
  - lookup_stall = lookup_req_IF.
  - No read is issued.
- Transitions:
  - NORMAL -> FORCE_DRAIN when count_next == DEPTH.
  - FORCE_DRAIN -> NORMAL when count_next <= DEPTH/2.
- Push on a full FIFO occurs only in FORCE_DRAIN. Pop happens in the same cycle, so push+pop leaves count unchanged. No overflow is possible. Push+pop in the same cycle at any occupancy leaves count unchanged.
- Bypass: lookup_idx_IF is compared against all valid entries, including the head being popped this cycle.
  - On any match: byp_vld=1 and byp_taken = value of the youngest matching entry.
  - The current cycle's push is not included.
  - byp_vld=0 when lookup_req_IF=0 or lookup_stall=1.
- tbl_wdata = 0 whenever tbl_we=0.
- Pop on an empty FIFO never occurs. Head/tail pointers wrap modulo DEPTH.

Decomposition:
- Package brch_pred_pkg holds:
  - enum upd_state_e {NORMAL, FORCE_DRAIN}
  - struct brch_upd_t {logic [IDX_W-1:0] idx; logic taken;}
  - default IDX_W/DEPTH constants
- Sub-module brch_upd_fifo holds storage, pointers, count and the parallel bypass-match/youngest-select logic. The top level holds the FSM, port arbitration, flush and counters.

Test Plan:
- Reset, then res_vld idx=3 taken=1, predicted=0 with no lookups -> mispredict_flush=1 same cycle. Next cycle: tbl_we=1, tbl_idx=3, tbl_wdata=1; fifo_count returns to 0. brch_cnt=1, mispred_cnt=1.
- Push idx=7 taken=0, then idx=7 taken=1 while lookup_req_IF held at idx=7 -> read issued each cycle, byp_vld=1; byp_taken=0 then 1 (youngest wins). No writes while the lookup persists.
- Continuous lookups plus 4 resolutions (DEPTH=4) -> FORCE_DRAIN entered as count reaches 4; lookup_stall=1 with writes on consecutive cycles. Return to NORMAL once count <= 2; lookup_stall drops the same cycle.
- res_vld while full in FORCE_DRAIN -> push and pop the same cycle, count stays 4, no entry lost. Write order matches push order.
- brch_resolved_ID=1 with stall_ID=1 and actual != predicted -> no push, no flush, counters unchanged.
- rst_n=0 with 3 pending entries and FORCE_DRAIN active -> next cycle fifo_count=0, NORMAL, tbl_en=0 with no lookup, byp_vld=0, counters 0. Force counters to max-1 and resolve twice -> brch_cnt holds at all-ones.
